uart_rx_os: RTL and testbench

16x-oversampling UART receiver that produces the byte stream consumed by the UART RX buffer and FIFO stage. It replaces direct bit sampling with a synchronised, majority-voted sampler and optional parity check. It delivers each byte through a one-entry holding register with a valid/ready handshake, plus per-byte error flags.

---
 rtl/uart_rx_os.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_os.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_os : 16x oversampling UART receiver, majority vote, parity, hold reg
// Revision   : 1.0
// ---------------------------------------------------------------------------
module uart_rx_os #(
  parameter int n      = 8,
  parameter int DIV    = 27,
  parameter int PARITY = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         Rx_i,
  input  logic         ready_i,
  output logic [n-1:0] data_o,
  output logic         valid_o,
  output logic         frame_err_o,
  output logic         parity_err_o,
  output logic         overrun_o,
  output logic         busy_o
);

  localparam int                 DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [2:0]         LAST_BIT = 3'(n - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             rx_meta_q, rx_s_q, rx_p_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       s_cnt_q, s_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       samp_q, samp_d;
  logic [n-1:0]     shift_q, shift_d;
  logic             par_q, par_d;
  logic             par_err_q, par_err_d;
  logic [n-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             pe_q, pe_d;
  logic             ovr_q, ovr_d;

  logic start_det, tick, decide, bit_end, vote, load;

  assign start_det = (state_q == S_IDLE) && rx_p_q && !rx_s_q;
  assign tick      = (state_q != S_IDLE) && (div_cnt_q == DIV_LAST);
  assign decide    = tick && (s_cnt_q == 4'd9);
  assign bit_end   = tick && (s_cnt_q == 4'd15);
  // third sample is the live rx_s on the s_cnt==9 tick
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign load      = (state_q == S_STOP) && decide;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_det) state_d = S_START;
      S_START: begin
        if (decide && vote) state_d = S_IDLE;
        else if (bit_end)   state_d = S_DATA;
      end
      S_DATA:   if (bit_end && bit_cnt_q == LAST_BIT)
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (decide) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    s_cnt_d   = s_cnt_q;
    bit_cnt_d = bit_cnt_q;
    samp_d    = samp_q;
    shift_d   = shift_q;
    par_d     = par_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = fe_q;
    pe_d      = pe_q;
    ovr_d     = 1'b0;

    if (state_q == S_IDLE) begin
      div_cnt_d = '0;
      s_cnt_d   = '0;
    end else if (tick) begin
      div_cnt_d = '0;
      s_cnt_d   = s_cnt_q + 4'd1;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (tick && s_cnt_q == 4'd7) samp_d[0] = rx_s_q;
    if (tick && s_cnt_q == 4'd8) samp_d[1] = rx_s_q;

    if (start_det) begin
      bit_cnt_d = '0;
      par_d     = 1'b0;
      par_err_d = 1'b0;
    end

    if (state_q == S_DATA && decide) begin
      shift_d = {vote, shift_q[n-1:1]};
      par_d   = par_q ^ vote;
    end
    if (state_q == S_DATA && bit_end && bit_cnt_q != LAST_BIT)
      bit_cnt_d = bit_cnt_q + 3'd1;
    if (state_q == S_PARITY && decide)
      par_err_d = (PARITY == 1) ? (par_q ^ vote) : ~(par_q ^ vote);

    // a load in the acceptance cycle replaces the byte being consumed
    if (load && (!valid_q || ready_i)) begin
      data_d  = shift_q;
      fe_d    = ~vote;
      pe_d    = (PARITY != 0) && par_err_q;
      valid_d = 1'b1;
    end else if (load) begin
      ovr_d   = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_p_q    <= 1'b1;
      div_cnt_q <= '0;
      s_cnt_q   <= '0;
      bit_cnt_q <= '0;
      samp_q    <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= Rx_i;
      rx_s_q    <= rx_meta_q;
      rx_p_q    <= rx_s_q;
      div_cnt_q <= div_cnt_d;
      s_cnt_q   <= s_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      samp_q    <= samp_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign frame_err_o  = fe_q;
  assign parity_err_o = pe_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_os : directed bench for uart_rx_os (no-parity and even-parity)
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_os;

  localparam int PER = 432;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       rx = 1'b1;
  logic       ready0 = 1'b1;
  logic       ready1 = 1'b1;
  logic [7:0] data0, data1;
  logic       valid0, fe0, pe0, ovr0, busy0;
  logic       valid1, fe1, pe1, ovr1, busy1;

  always #5 clk = ~clk;

  uart_rx_os #(.n(8), .DIV(27), .PARITY(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .Rx_i(rx), .ready_i(ready0),
    .data_o(data0), .valid_o(valid0), .frame_err_o(fe0),
    .parity_err_o(pe0), .overrun_o(ovr0), .busy_o(busy0)
  );

  uart_rx_os #(.n(8), .DIV(27), .PARITY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .Rx_i(rx), .ready_i(ready1),
    .data_o(data1), .valid_o(valid1), .frame_err_o(fe1),
    .parity_err_o(pe1), .overrun_o(ovr1), .busy_o(busy1)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         t;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   t_fall = 0;
  int   ovr_cnt = 0;
  int   ovr_t = 0;
  int   v0_len = 0;
  int   last_len0 = 0;
  logic v0_prev = 1'b0;
  logic v1_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid0 && !v0_prev) q0.push_back('{data0, fe0, pe0, cyc});
    if (valid1 && !v1_prev) q1.push_back('{data1, fe1, pe1, cyc});
    if (valid0) v0_len = v0_len + 1;
    else if (v0_prev) begin last_len0 = v0_len; v0_len = 0; end
    if (ovr0) begin ovr_cnt = ovr_cnt + 1; ovr_t = cyc; end
    v0_prev = valid0;
    v1_prev = valid1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    n_assert++;
    assert (v >= lo && v <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int p);
    rx = b;
    repeat (p) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par,
                            input logic par_bit, input logic stop_bit);
    t_fall = cyc;
    send_bit(1'b0, PER);
    for (int i = 0; i < 8; i++) send_bit(d[i], PER);
    if (with_par) send_bit(par_bit, PER);
    send_bit(stop_bit, PER);
    rx = 1'b1;
  endtask

  task automatic send_jitter(input logic [7:0] d);
    int         per [10] = '{444, 444, 444, 420, 420, 420, 444, 444, 420, 420};
    logic [9:0] fb;
    fb = {1'b1, d, 1'b0};
    t_fall = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        rx = fb[i];
        repeat (per[i] / 2 - 10) @(negedge clk);
        rx = ~fb[i];
        repeat (20) @(negedge clk);
        rx = fb[i];
        repeat (per[i] - per[i] / 2 - 10) @(negedge clk);
      end else begin
        send_bit(fb[i], per[i]);
      end
    end
    rx = 1'b1;
  endtask

  int t0, t_drop;
  logic saw_drop;

  initial begin
    // reset state
    idle(5);
    chk("rst_valid", valid0, 0);
    chk("rst_data", data0, 0);
    chk("rst_fe", fe0, 0);
    chk("rst_pe", pe0, 0);
    chk("rst_ovr", ovr0, 0);
    chk("rst_busy", busy0, 0);
    rst_i = 1'b1;
    idle(20);

    // basic byte
    q0.delete(); q1.delete();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    idle(1000);
    chk("basic_cnt", q0.size(), 1);
    if (q0.size() > 0) begin
      chk("basic_data", q0[0].d, 8'h55);
      chk("basic_fe", q0[0].fe, 0);
      chk("basic_pe", q0[0].pe, 0);
      chk_rng("basic_lat", q0[0].t - t_fall, 4160, 4162);
    end
    chk("basic_vlen", last_len0, 1);
    chk("basic_busy", busy0, 0);

    // even parity, correct and wrong parity bit
    q0.delete(); q1.delete();
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1);
    idle(1000);
    chk("par_ok_cnt", q1.size(), 1);
    if (q1.size() > 0) begin
      chk("par_ok_data", q1[0].d, 8'hA3);
      chk("par_ok_pe", q1[0].pe, 0);
      chk("par_ok_fe", q1[0].fe, 0);
      chk_rng("par_lat", q1[0].t - t_fall, 4592, 4594);
    end
    q1.delete();
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
    idle(1000);
    chk("par_bad_cnt", q1.size(), 1);
    if (q1.size() > 0) begin
      chk("par_bad_data", q1[0].d, 8'hA3);
      chk("par_bad_pe", q1[0].pe, 1);
    end

    // false start
    q0.delete();
    t0 = cyc;
    rx = 1'b0;
    idle(50);
    chk("fs_busy_hi", busy0, 1);
    idle(50);
    rx = 1'b1;
    saw_drop = 1'b0;
    t_drop = 0;
    for (int i = 0; i < 600 && !saw_drop; i++) begin
      @(negedge clk);
      if (!busy0) begin saw_drop = 1'b1; t_drop = cyc; end
    end
    chk("fs_drop_seen", saw_drop, 1);
    chk_rng("fs_drop_time", t_drop - t0, 272, 274);
    idle(1000);
    chk("fs_no_valid", q0.size(), 0);

    // framing error, then line held low
    q0.delete();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    idle(600);
    chk("fe_cnt", q0.size(), 1);
    if (q0.size() > 0) begin
      chk("fe_data", q0[0].d, 8'h3C);
      chk("fe_flag", q0[0].fe, 1);
      chk("fe_pe", q0[0].pe, 0);
    end
    idle(3000);
    chk("brk_cnt", q0.size(), 1);
    chk("brk_busy", busy0, 0);
    rx = 1'b1;
    idle(1000);

    // overrun on back-to-back frames with ready low
    q0.delete();
    ready0 = 1'b0;
    ovr_cnt = 0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    idle(600);
    chk("ovr_cnt_rx", q0.size(), 1);
    chk("ovr_held", data0, 8'h11);
    chk("ovr_valid", valid0, 1);
    chk("ovr_pulses", ovr_cnt, 1);
    chk_rng("ovr_time", ovr_t - t_fall, 4160, 4162);
    ready0 = 1'b1;
    chk("acc_before", valid0, 1);
    @(negedge clk);
    chk("acc_drop", valid0, 0);
    idle(500);

    // back-to-back with ready high
    q0.delete();
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle(1000);
    chk("b2b_cnt", q0.size(), 3);
    if (q0.size() == 3) begin
      chk("b2b_d0", q0[0].d, 8'h00);
      chk("b2b_d1", q0[1].d, 8'hFF);
      chk("b2b_d2", q0[2].d, 8'h81);
      chk("b2b_fe", {q0[0].fe, q0[1].fe, q0[2].fe}, 0);
    end

    // asynchronous reset during data bit 4
    q0.delete();
    fork
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      begin
        idle(PER * 5 + 200);
        chk("mid_busy", busy0, 1);
        #2 rst_i = 1'b0;
        #1;
        chk("mid_busy0", busy0, 0);
        chk("mid_data0", data0, 0);
        chk("mid_valid0", valid0, 0);
      end
    join
    idle(100);
    rst_i = 1'b1;
    idle(200);
    chk("mid_novalid", q0.size(), 0);
    chk("mid_noovr", ovr0, 0);
    chk("mid_idle", busy0, 0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    idle(1000);
    chk("c3_cnt", q0.size(), 1);
    if (q0.size() > 0) begin
      chk("c3_data", q0[0].d, 8'hC3);
      chk("c3_flags", {q0[0].fe, q0[0].pe}, 0);
    end

    // jitter and mid-bit glitch
    q0.delete();
    send_jitter(8'h96);
    idle(1000);
    chk("jit_cnt", q0.size(), 1);
    if (q0.size() > 0) begin
      chk("jit_data", q0[0].d, 8'h96);
      chk("jit_flags", {q0[0].fe, q0[0].pe}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
